// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// the hard-wired zero register number and the default memory watchdog limit.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO            = 5'd0;
   localparam int         DEFAULT_MEM_TIMEOUT = 15;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EXE whose destination is read by the instruction in ID.
// Writes to $zero never create a dependency.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] src1,
   input  logic [4:0] src2,
   input  logic       two_src,
   input  logic [4:0] exe_dest,
   input  logic       exe_mem_r_en,
   output logic       load_use
);

   assign load_use = exe_mem_r_en && (exe_dest != REG_ZERO) &&
                     ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a memory-wait watchdog.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
`ifdef PIPE_PERF_CNT_EN
   ,parameter int CNT_W = 32
`endif
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] src1,
   input  logic [4:0] src2,
   input  logic       two_src,
   input  logic [4:0] exe_dest,
   input  logic       exe_mem_r_en,
   input  logic       br_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       freeze_pc,
   output logic       freeze_if_id,
   output logic       flush_if_id,
   output logic       freeze_id_exe,
   output logic       flush_id_exe,
   output logic       freeze_exe_mem,
   output logic       mem_err,
   output logic [1:0] state
`ifdef PIPE_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
   ,output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             load_use;
   logic             mem_stall;

   load_use_detect u_load_use_detect (
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .exe_dest     (exe_dest),
      .exe_mem_r_en (exe_mem_r_en),
      .load_use     (load_use)
   );

   assign mem_stall = mem_req && !mem_ready;
   assign state     = state_q;
   assign mem_err   = mem_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // A taken branch kills the ID instruction, so it overrides any load-use stall.
   always_comb begin
      freeze_pc      = 1'b0;
      freeze_if_id   = 1'b0;
      flush_if_id    = 1'b0;
      freeze_id_exe  = 1'b0;
      flush_id_exe   = 1'b0;
      freeze_exe_mem = 1'b0;
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      mem_err_d      = mem_err_q;
      if (!rst) begin
         case (state_q)
            MEM_WAIT: begin
               if (mem_ready || !mem_req) begin
                  state_d    = RUN;
                  wait_cnt_d = '0;
                  if (br_taken) begin
                     flush_if_id  = 1'b1;
                     flush_id_exe = 1'b1;
                  end else if (load_use) begin
                     freeze_pc    = 1'b1;
                     freeze_if_id = 1'b1;
                     flush_id_exe = 1'b1;
                  end
               end else begin
                  freeze_pc      = 1'b1;
                  freeze_if_id   = 1'b1;
                  freeze_id_exe  = 1'b1;
                  freeze_exe_mem = 1'b1;
                  wait_cnt_d     = wait_cnt_q + WCW'(1);
                  if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
                     state_d   = ERR;
                     mem_err_d = 1'b1;
                  end
               end
            end
            ERR: begin
               freeze_pc      = 1'b1;
               freeze_if_id   = 1'b1;
               freeze_id_exe  = 1'b1;
               freeze_exe_mem = 1'b1;
               mem_err_d      = 1'b1;
            end
            default: begin
               // The unused encoding behaves like RUN but always returns to RUN.
               state_d    = RUN;
               wait_cnt_d = '0;
               if (mem_stall) begin
                  freeze_pc      = 1'b1;
                  freeze_if_id   = 1'b1;
                  freeze_id_exe  = 1'b1;
                  freeze_exe_mem = 1'b1;
                  if (state_q == RUN) begin
                     state_d    = MEM_WAIT;
                     wait_cnt_d = WCW'(1);
                  end
               end else if (br_taken) begin
                  flush_if_id  = 1'b1;
                  flush_id_exe = 1'b1;
               end else if (load_use) begin
                  freeze_pc    = 1'b1;
                  freeze_if_id = 1'b1;
                  flush_id_exe = 1'b1;
               end
            end
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (freeze_pc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_if_id && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: a vector table for the
// single-cycle hazard rules plus hand sequences for memory wait and watchdog.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 15;
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LU   = 6'b110010;
   localparam logic [5:0] C_BR   = 6'b001010;
   localparam logic [5:0] C_ALL  = 6'b110101;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] src1, src2, exe_dest;
   logic       two_src, exe_mem_r_en, br_taken, mem_req, mem_ready;
   logic       freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe, freeze_exe_mem;
   logic       mem_err;
   logic [1:0] state;
   logic [5:0] ctrl;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic [4:0] src1;
      logic [4:0] src2;
      logic       two_src;
      logic [4:0] exe_dest;
      logic       exe_mem_r_en;
      logic       br_taken;
      logic       mem_req;
      logic       mem_ready;
      logic [5:0] exp_ctrl;
   } vec_t;

   vec_t vecs[9];

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
`ifdef PIPE_PERF_CNT_EN
      ,.CNT_W      (32)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .src1           (src1),
      .src2           (src2),
      .two_src        (two_src),
      .exe_dest       (exe_dest),
      .exe_mem_r_en   (exe_mem_r_en),
      .br_taken       (br_taken),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .freeze_pc      (freeze_pc),
      .freeze_if_id   (freeze_if_id),
      .flush_if_id    (flush_if_id),
      .freeze_id_exe  (freeze_id_exe),
      .flush_id_exe   (flush_id_exe),
      .freeze_exe_mem (freeze_exe_mem),
      .mem_err        (mem_err),
      .state          (state)
`ifdef PIPE_PERF_CNT_EN
      ,.stall_cnt     (stall_cnt)
      ,.flush_cnt     (flush_cnt)
`endif
   );

   assign ctrl = {freeze_pc, freeze_if_id, flush_if_id, freeze_id_exe, flush_id_exe, freeze_exe_mem};

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2, input logic ts,
                                input logic [4:0] ed, input logic re, input logic bt,
                                input logic mq, input logic mr);
      src1 = s1; src2 = s2; two_src = ts; exe_dest = ed;
      exe_mem_r_en = re; br_taken = bt; mem_req = mq; mem_ready = mr;
   endtask

   task automatic checkOutput(input string name, input logic [5:0] ec, input logic [1:0] es, input logic ee);
      #1;
      checks++;
      if ({ctrl, state, mem_err} !== {ec, es, ee}) begin
         failures++;
         $display("[TB] FAIL %s: got ctrl=%b state=%0d mem_err=%b, expected ctrl=%b state=%0d mem_err=%b",
                  name, ctrl, state, mem_err, ec, es, ee);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"lu_src1",        5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
      vecs[1] = '{"src2_no_two",    5'd3, 5'd2, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
      vecs[2] = '{"lu_src2_two",    5'd3, 5'd2, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
      vecs[3] = '{"dest_zero",      5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
      vecs[4] = '{"no_load",        5'd2, 5'd2, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
      vecs[5] = '{"br_over_lu",     5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, C_BR};
      vecs[6] = '{"br_alone",       5'd4, 5'd5, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, C_BR};
      vecs[7] = '{"mem_ready_lu",   5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, C_LU};
      vecs[8] = '{"idle",           5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};

      rst = 1'b1;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("reset_hold", C_NONE, 2'd0, 1'b0);
      tick();
      checkOutput("reset_hold2", C_NONE, 2'd0, 1'b0);
      doReset();

`ifdef PIPE_PERF_CNT_EN
      applyStimulus(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); tick(); tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt !== 32'd4 || flush_cnt !== 32'd0) begin
         failures++;
         $display("[TB] FAIL perf_stall: got stall=%0d flush=%0d, expected stall=4 flush=0", stall_cnt, flush_cnt);
      end
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt !== 32'd4 || flush_cnt !== 32'd1) begin
         failures++;
         $display("[TB] FAIL perf_flush: got stall=%0d flush=%0d, expected stall=4 flush=1", stall_cnt, flush_cnt);
      end
      doReset();
`endif

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].src1, vecs[i].src2, vecs[i].two_src, vecs[i].exe_dest,
                       vecs[i].exe_mem_r_en, vecs[i].br_taken, vecs[i].mem_req, vecs[i].mem_ready);
         checkOutput(vecs[i].name, vecs[i].exp_ctrl, 2'd0, 1'b0);
         tick();
      end

      // Load-use bubble lasts one cycle, then the load has moved on.
      applyStimulus(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("bubble_cycle", C_LU, 2'd0, 1'b0);
      tick();
      applyStimulus(5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bubble_done", C_NONE, 2'd0, 1'b0);
      tick();

      // Three wait cycles, then ready releases the freezes.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("wait_c1", C_ALL, 2'd0, 1'b0);
      tick();
      checkOutput("wait_c2", C_ALL, 2'd1, 1'b0);
      tick();
      checkOutput("wait_c3", C_ALL, 2'd1, 1'b0);
      tick();
      mem_ready = 1'b1;
      checkOutput("wait_ready", C_NONE, 2'd1, 1'b0);
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("wait_back_run", C_NONE, 2'd0, 1'b0);
      tick();

      // Ready cycle with a taken branch applies the branch flush.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("ready_branch", C_BR, 2'd1, 1'b0);
      tick();

      // mem_req dropping without ready aborts the wait.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("abort_lu", C_LU, 2'd1, 1'b0);
      tick();
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort_run", C_NONE, 2'd0, 1'b0);
      tick();

      // Watchdog: 15 frozen cycles, then ERR sticks until reset.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         checkOutput($sformatf("wd_cycle%0d", i), C_ALL, (i == 0) ? 2'd0 : 2'd1, 1'b0);
         tick();
      end
      applyStimulus(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("err_entered", C_ALL, 2'd2, 1'b1);
      tick();
      checkOutput("err_sticky", C_ALL, 2'd2, 1'b1);
      rst = 1'b1;
      tick();
      checkOutput("err_reset", C_NONE, 2'd0, 1'b0);
      rst = 1'b0;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("err_cleared", C_NONE, 2'd0, 1'b0);
      tick();

      // Reset in the middle of a memory wait.
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(); tick(); tick();
      checkOutput("mid_wait", C_ALL, 2'd1, 1'b0);
      rst = 1'b1;
      tick();
      checkOutput("mid_wait_rst", C_NONE, 2'd0, 1'b0);
      rst = 1'b0;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mid_wait_run", C_NONE, 2'd0, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
